dac_src_mux: RTL and testbench

Parametrised, glitch-safe source selector feeding the DAC data bus. It chooses one of `NUM_SRC` offset-binary sample streams (DDS, AM, and future generators) and registers it onto the DAC port. On every source change it inserts a timed midscale mute, so the DAC never jumps directly between unrelated waveforms. It also provides an external mute request and status outputs for the control logic. It sits between the signal generators and the DAC output pins.

---
 rtl/dac_pkg.sv | 14 +
 rtl/mute_timer.sv | 30 +++
 rtl/dac_src_mux.sv | 105 ++++++++++
 tb/tb_dac_src_mux.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC source selector.
// Offset-binary samples have their zero level at the midscale code.
package dac_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    MUTE = 1'b1
  } state_t;

  function automatic int unsigned midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/mute_timer.sv
// Loadable down-counter that times the midscale gap between sources.
// It holds at zero rather than wrapping if decremented past the end.
module mute_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/dac_src_mux.sv
// Glitch-safe DAC source selector.
// Every source change is bridged by a fixed run of midscale samples.
module dac_src_mux
  import dac_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_SRC     = 4,
  parameter int MUTE_CYCLES = 16,
  parameter int SEL_W       = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     mute_req,
  output logic [WIDTH-1:0]         dac,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     busy
);

  localparam int               CW       = $clog2(MUTE_CYCLES + 1);
  localparam logic [WIDTH-1:0] MID      = WIDTH'(midscale(WIDTH));
  localparam logic [CW-1:0]    LOAD_VAL = CW'(MUTE_CYCLES - 1);
  localparam logic [SEL_W:0]   SRC_LIM  = (SEL_W + 1)'(NUM_SRC);

  logic [WIDTH-1:0] src_arr [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign src_arr[gi] = src_data[gi*WIDTH +: WIDTH];
  end

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] active_reg, active_next;
  logic [SEL_W-1:0] target_reg, target_next;
  logic [WIDTH-1:0] dac_reg, dac_next;
  logic             busy_reg, busy_next;
  logic             load, dec, zero;
  logic [CW-1:0]    cnt;
  logic             sel_ok;

  assign sel_ok = ({1'b0, sel} < SRC_LIM);

  mute_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .dec      (dec),
    .load_val (LOAD_VAL),
    .cnt      (cnt),
    .zero     (zero)
  );

  always_comb begin
    state_next  = state_reg;
    active_next = active_reg;
    target_next = target_reg;
    load        = 1'b0;
    dec         = 1'b0;
    case (state_reg)
      RUN: begin
        target_next = active_reg;
        if (sel_ok && (sel != active_reg)) begin
          state_next  = MUTE;
          load        = 1'b1;
          target_next = sel;
        end
      end
      MUTE: begin
        dec = 1'b1;
        // Out-of-range selects mid-switch keep the last valid destination.
        if (sel_ok) begin
          target_next = sel;
        end
        if (zero) begin
          state_next  = RUN;
          active_next = target_next;
        end
      end
      default: state_next = RUN;
    endcase
    busy_next = (state_next == MUTE);
    dac_next  = (mute_req || (state_next == MUTE)) ? MID : src_arr[active_next];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      active_reg <= '0;
      target_reg <= '0;
      dac_reg    <= MID;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      active_reg <= active_next;
      target_reg <= target_next;
      dac_reg    <= dac_next;
      busy_reg   <= busy_next;
    end
  end

  assign dac        = dac_reg;
  assign active_sel = active_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_dac_src_mux.sv
// Directed bench for dac_src_mux: a 4-source and a 3-source instance,
// both with 16 mute cycles, checked with immediate assertions.
module tb_dac_src_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel, sel3;
  logic [31:0] src;
  logic [23:0] src3;
  logic        mute, mute3;
  logic [7:0]  dac, dac3;
  logic [1:0]  act, act3;
  logic        busy, busy3;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dac_src_mux #(.WIDTH(8), .NUM_SRC(4), .MUTE_CYCLES(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .src_data(src), .mute_req(mute),
    .dac(dac), .active_sel(act), .busy(busy)
  );

  dac_src_mux #(.WIDTH(8), .NUM_SRC(3), .MUTE_CYCLES(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .sel(sel3), .src_data(src3), .mute_req(mute3),
    .dac(dac3), .active_sel(act3), .busy(busy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n edges of an ongoing switch on the 4-source instance
  task automatic mute_run(input string tag, input int n, input logic [1:0] old_act);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_dac"}, dac, 8'h80);
      chk({tag, "_act"}, act, old_act);
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = 2'd0; sel3 = 2'd0; mute = 1'b0; mute3 = 1'b0;
    src  = 32'h44332211;
    src3 = 24'h332211;

    // reset
    repeat (3) step();
    chk("rst_dac", dac, 8'h80);
    chk("rst_act", act, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dac3", dac3, 8'h80);
    rst_n = 1'b1;
    step();
    chk("rel_dac", dac, 8'h11);
    chk("rel_dac3", dac3, 8'h11);

    // one-cycle routing latency
    src = 32'h443322a5;
    step();
    chk("lat_dac", dac, 8'ha5);
    src = 32'h44332211;
    step();
    chk("lat_dac2", dac, 8'h11);

    // out-of-range select in RUN on the 3-source instance
    sel3 = 2'd3;
    step(); step();
    chk("oor_busy", busy3, 0);
    chk("oor_act", act3, 0);
    chk("oor_dac", dac3, 8'h11);

    // retarget 1 -> 2, then out of range on the final mute edge
    sel3 = 2'd1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("oor_mute_busy", busy3, 1);
      chk("oor_mute_dac", dac3, 8'h80);
      if (i == 3) sel3 = 2'd2;
    end
    sel3 = 2'd3;
    step();
    chk("oor_end_busy", busy3, 0);
    chk("oor_end_act", act3, 2);
    chk("oor_end_dac", dac3, 8'h33);
    sel3 = 2'd2;

    // plain switch 0 -> 2
    sel = 2'd2;
    mute_run("sw02", 16, 2'd0);
    step();
    chk("sw02_busy", busy, 0);
    chk("sw02_act", act, 2);
    chk("sw02_dac", dac, 8'h33);
    src = 32'h44c72211;
    step();
    chk("sw02_follow", dac, 8'hc7);
    src = 32'h44332211;

    // back to 0
    sel = 2'd0;
    mute_run("sw20", 16, 2'd2);
    step();
    chk("sw20_act", act, 0);
    chk("sw20_dac", dac, 8'h11);

    // retarget 0 -> 1 -> 3 after 5 mute cycles
    sel = 2'd1;
    mute_run("rt13a", 5, 2'd0);
    sel = 2'd3;
    mute_run("rt13b", 11, 2'd0);
    step();
    chk("rt13_busy", busy, 0);
    chk("rt13_act", act, 3);
    chk("rt13_dac", dac, 8'h44);

    // go elsewhere then return to the old source mid-mute
    sel = 2'd2;
    mute_run("ret_a", 5, 2'd3);
    sel = 2'd3;
    mute_run("ret_b", 11, 2'd3);
    step();
    chk("ret_busy", busy, 0);
    chk("ret_act", act, 3);
    chk("ret_dac", dac, 8'h44);
    step();
    chk("ret_idle", busy, 0);

    // back-to-back switches with no RUN dwell
    sel = 2'd1;
    mute_run("b2b_a", 16, 2'd3);
    step();
    chk("b2b_act1", act, 1);
    chk("b2b_dac1", dac, 8'h22);
    chk("b2b_busy1", busy, 0);
    sel = 2'd0;
    mute_run("b2b_b", 16, 2'd1);
    step();
    chk("b2b_act0", act, 0);
    chk("b2b_dac0", dac, 8'h11);

    // external mute in RUN
    mute = 1'b1;
    step();
    chk("mreq_dac", dac, 8'h80);
    chk("mreq_busy", busy, 0);
    mute = 1'b0;
    step();
    chk("mreq_rel", dac, 8'h11);

    // external mute held across a switch
    mute = 1'b1;
    sel = 2'd2;
    mute_run("msw", 16, 2'd0);
    step();
    chk("msw_busy", busy, 0);
    chk("msw_act", act, 2);
    chk("msw_dac", dac, 8'h80);
    mute = 1'b0;
    step();
    chk("msw_rel", dac, 8'h33);

    // reset on the 8th mute cycle
    sel = 2'd1;
    mute_run("rsw", 7, 2'd2);
    rst_n = 1'b0;
    sel = 2'd0;
    sel3 = 2'd0;
    step();
    chk("rsw_busy", busy, 0);
    chk("rsw_act", act, 0);
    chk("rsw_dac", dac, 8'h80);
    rst_n = 1'b1;
    step();
    chk("rsw_rel_busy", busy, 0);
    chk("rsw_rel_dac", dac, 8'h11);
    step();
    chk("rsw_rel_busy2", busy, 0);
    chk("rsw_rel_act", act, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
